// File: rtl/mem_fill_sequencer_if.sv
// Control and write-bus signals between a fill sequencer and its controller/memory side.
// The sequencer connects through the slave modport; the controller side uses master.
interface mem_fill_sequencer_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
);
  logic              iTick;
  logic              iStart;
  logic              iStop;
  logic              iLoop;
  logic              iAck;
  logic [ADDR_W-1:0] oAddr;
  logic [DATA_W-1:0] oData;
  logic              oWe;
  logic              oBusy;
  logic              oDone;
  logic              oOverrun;

  modport master (
    output iTick, iStart, iStop, iLoop, iAck,
    input  oAddr, oData, oWe, oBusy, oDone, oOverrun
  );

  modport slave (
    input  iTick, iStart, iStop, iLoop, iAck,
    output oAddr, oData, oWe, oBusy, oDone, oOverrun
  );
endinterface

// File: rtl/mem_fill_sequencer.sv
// Tick-paced frame-buffer fill: writes an address/data ramp one word per accepted
// tick, holding each write request until acknowledged, with optional wrap-around.
module mem_fill_sequencer #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LAST_ADDR = 4095,
  parameter int unsigned DATA_INIT = 0,
  parameter int unsigned DATA_STEP = 1
) (
  input logic                  iClk,
  input logic                  iRst_n,
  mem_fill_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, WRITE, DONE} state_t;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic              we_q, we_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              ovr_q, ovr_n;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
  localparam logic [DATA_W-1:0] INIT = DATA_W'(DATA_INIT);
  localparam logic [DATA_W-1:0] STEP = DATA_W'(DATA_STEP);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= INIT;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
      we_q    <= we_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      ovr_q   <= ovr_n;
    end
  end

  // Status outputs are decoded from the next state so they register alongside it.
  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    data_n  = data_q;
    ovr_n   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          state_n = ARMED;
          addr_n  = '0;
          data_n  = INIT;
          ovr_n   = 1'b0;
        end
      end
      ARMED: begin
        if (bus.iStop)      state_n = IDLE;
        else if (bus.iTick) state_n = WRITE;
      end
      WRITE: begin
        if (bus.iStop) begin
          state_n = IDLE;
        end else begin
          if (bus.iTick) ovr_n = 1'b1;
          if (bus.iAck) begin
            if (addr_q != LAST) begin
              state_n = ARMED;
              addr_n  = addr_q + 1'b1;
              data_n  = data_q + STEP;
            end else if (bus.iLoop) begin
              state_n = ARMED;
              addr_n  = '0;
              data_n  = INIT;
            end else begin
              state_n = DONE;
            end
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    we_n   = (state_n == WRITE);
    busy_n = (state_n == ARMED) || (state_n == WRITE);
    done_n = (state_n == DONE);
  end

  assign bus.oAddr    = addr_q;
  assign bus.oData    = data_q;
  assign bus.oWe      = we_q;
  assign bus.oBusy    = busy_q;
  assign bus.oDone    = done_q;
  assign bus.oOverrun = ovr_q;

endmodule

// File: tb/tb_mem_fill_sequencer.sv
// Directed bench for mem_fill_sequencer with LAST_ADDR=3, DATA_INIT=0x10, DATA_STEP=2.
module tb_mem_fill_sequencer;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  mem_fill_sequencer_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  mem_fill_sequencer #(
    .ADDR_W(12), .DATA_W(8), .LAST_ADDR(3), .DATA_INIT(8'h10), .DATA_STEP(2)
  ) dut (
    .iClk  (clk),
    .iRst_n(rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass();
    bus.iStart = 1'b1;
    step();
    bus.iStart = 1'b0;
  endtask

  task automatic tick_pulse();
    bus.iTick = 1'b1;
    step();
    bus.iTick = 1'b0;
  endtask

  // Tick, verify the request for one held cycle, then acknowledge.
  task automatic do_write(input logic [11:0] ea, input logic [7:0] ed);
    tick_pulse();
    check("we_up", bus.oWe, 1);
    check("addr", bus.oAddr, ea);
    check("data", bus.oData, ed);
    step();
    check("we_hold", bus.oWe, 1);
    check("addr_hold", bus.oAddr, ea);
    bus.iAck = 1'b1;
    step();
    bus.iAck = 1'b0;
    check("we_drop", bus.oWe, 0);
  endtask

  initial begin
    bus.iTick = 0; bus.iStart = 0; bus.iStop = 0; bus.iLoop = 0; bus.iAck = 0;
    rst_n = 1'b0;
    #12;
    check("rst_addr", bus.oAddr, 0);
    check("rst_data", bus.oData, 8'h10);
    check("rst_we", bus.oWe, 0);
    check("rst_busy", bus.oBusy, 0);
    check("rst_done", bus.oDone, 0);
    check("rst_ovr", bus.oOverrun, 0);
    step();
    rst_n = 1'b1;
    step();

    // Single pass, no loop
    tick_pulse();
    check("idle_tick_we", bus.oWe, 0);
    check("idle_tick_ovr", bus.oOverrun, 0);
    start_pass();
    check("armed_busy", bus.oBusy, 1);
    for (int i = 0; i < 4; i++) begin
      do_write(12'(i), 8'(8'h10 + 2 * i));
      check("pass_done", bus.oDone, (i == 3) ? 1 : 0);
      check("pass_busy", bus.oBusy, (i == 3) ? 0 : 1);
    end
    step();
    check("done_clear", bus.oDone, 0);
    check("idle_busy", bus.oBusy, 0);
    check("pass_ovr", bus.oOverrun, 0);
    tick_pulse();
    check("after_done_we", bus.oWe, 0);

    // Looping pass
    bus.iLoop = 1'b1;
    start_pass();
    for (int i = 0; i < 6; i++) begin
      do_write(12'(i % 4), 8'(8'h10 + 2 * (i % 4)));
      check("loop_done", bus.oDone, 0);
      check("loop_busy", bus.oBusy, 1);
    end
    bus.iStop = 1'b1;
    step();
    bus.iStop = 1'b0;
    check("loop_stop_busy", bus.oBusy, 0);
    check("loop_stop_done", bus.oDone, 0);
    bus.iLoop = 1'b0;

    // Dropped ticks
    start_pass();
    tick_pulse();
    check("ov_we", bus.oWe, 1);
    tick_pulse();
    check("ov_set", bus.oOverrun, 1);
    check("ov_we_hold", bus.oWe, 1);
    check("ov_addr_hold", bus.oAddr, 0);
    bus.iAck = 1'b1; bus.iTick = 1'b1;
    step();
    bus.iAck = 1'b0; bus.iTick = 1'b0;
    check("ov_ack_we", bus.oWe, 0);
    check("ov_ack_addr", bus.oAddr, 1);
    check("ov_ack_flag", bus.oOverrun, 1);
    do_write(12'd1, 8'h12);
    // Start while ARMED is ignored: address and sticky flag keep their values
    start_pass();
    check("armed_start_addr", bus.oAddr, 2);
    check("armed_start_ovr", bus.oOverrun, 1);
    check("armed_start_we", bus.oWe, 0);
    bus.iStop = 1'b1;
    step();
    bus.iStop = 1'b0;
    check("ov_stop_ovr", bus.oOverrun, 1);
    start_pass();
    check("ov_clear", bus.oOverrun, 0);

    // Stop during WRITE at address 2
    do_write(12'd0, 8'h10);
    do_write(12'd1, 8'h12);
    tick_pulse();
    check("stop_pre_addr", bus.oAddr, 2);
    bus.iStop = 1'b1; bus.iAck = 1'b1;
    step();
    bus.iStop = 1'b0; bus.iAck = 1'b0;
    check("stop_we", bus.oWe, 0);
    check("stop_busy", bus.oBusy, 0);
    check("stop_done", bus.oDone, 0);
    check("stop_addr", bus.oAddr, 2);
    check("stop_data", bus.oData, 8'h14);
    bus.iAck = 1'b1; bus.iTick = 1'b1;
    step();
    bus.iAck = 1'b0; bus.iTick = 1'b0;
    check("stop_ign_we", bus.oWe, 0);
    check("stop_ign_addr", bus.oAddr, 2);
    check("stop_ign_ovr", bus.oOverrun, 0);

    // Asynchronous reset mid-WRITE
    start_pass();
    do_write(12'd0, 8'h10);
    tick_pulse();
    check("ar_pre_we", bus.oWe, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_we", bus.oWe, 0);
    check("ar_busy", bus.oBusy, 0);
    check("ar_addr", bus.oAddr, 0);
    check("ar_data", bus.oData, 8'h10);
    step();
    rst_n = 1'b1;
    tick_pulse();
    check("ar_wait_we", bus.oWe, 0);
    check("ar_wait_busy", bus.oBusy, 0);
    start_pass();
    do_write(12'd0, 8'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim time exceeded budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_fill_sequencer.md
MEM_FILL_SEQUENCER -- requirements
Module: mem_fill_sequencer

Interface
REQ-001 Parameter ADDR_W, 12, frame-buffer address width.
REQ-002 Parameter DATA_W, 8, write-data width.
REQ-003 Parameter LAST_ADDR, 4095, final address of one fill pass.
REQ-004 Parameter DATA_INIT, 0, data value written at address 0.
REQ-005 Parameter DATA_STEP, 1, data increment per written address.
REQ-006 iClk  input  1  sole clock, rising edge.
REQ-007 iRst_n  input  1  reset, asynchronous, active-low.
REQ-008 iTick  input  1  one-cycle pacing pulse from the upstream frequency divider; each accepted pulse triggers one write.
REQ-009 iStart  input  1  starts a fill pass; sampled only in IDLE.
REQ-010 iStop  input  1  synchronous abort; returns to IDLE.
REQ-011 iLoop  input  1  when 1, wrap to address 0 after LAST_ADDR instead of finishing.
REQ-012 iAck  input  1  memory write acknowledge; completes the current write.
REQ-013 oAddr  output  ADDR_W  write address, registered.
REQ-014 oData  output  DATA_W  write data, registered.
REQ-015 oWe  output  1  write request, registered, held until iAck.
REQ-016 oBusy  output  1  high in ARMED and WRITE.
REQ-017 oDone  output  1  one-cycle pulse at end of a non-looping pass.
REQ-018 oOverrun  output  1  sticky flag: a tick was dropped.

Function
REQ-019 States SHALL be IDLE, ARMED, WRITE, DONE; all state and outputs registered on iClk.
REQ-020 IDLE + iStart: next cycle ARMED, oAddr=0, oData=DATA_INIT, oOverrun=0, oBusy=1.
REQ-021 iTick in IDLE or DONE SHALL be ignored; it SHALL NOT set oOverrun.
REQ-022 ARMED + iTick: next cycle WRITE with oWe=1 (one-cycle latency tick->oWe).
REQ-023 WRITE: oWe, oAddr, oData SHALL hold stable until iAck is sampled high.
REQ-024 WRITE + iAck with oAddr!=LAST_ADDR: next cycle ARMED, oWe=0, oAddr+1, oData+DATA_STEP mod 2^DATA_W.
REQ-025 WRITE + iAck with oAddr==LAST_ADDR and iLoop=1: next cycle ARMED, oAddr=0, oData=DATA_INIT.
REQ-026 WRITE + iAck with oAddr==LAST_ADDR and iLoop=0: next cycle DONE, oWe=0, oBusy=0, oDone=1; following cycle IDLE, oDone=0.
REQ-027 iTick sampled in WRITE (including the iAck cycle) SHALL be dropped and set oOverrun=1 next cycle.
REQ-028 oOverrun SHALL clear only on reset or an accepted iStart.
REQ-029 iStart outside IDLE SHALL be ignored.
REQ-030 iStop in ARMED or WRITE: next cycle IDLE, oWe=0, oBusy=0, no oDone; oAddr/oData hold their last values; iStop has priority over iAck and iTick.
REQ-031 oAddr SHALL never exceed LAST_ADDR; address arithmetic SHALL be ADDR_W wide.
REQ-032 Assertion of iAck while oWe=0 SHALL be ignored.

Reset
REQ-033 iRst_n low SHALL immediately force IDLE, oAddr=0, oData=DATA_INIT, oWe=0, oBusy=0, oDone=0, oOverrun=0, regardless of iClk.
REQ-034 Reset mid-WRITE SHALL drop oWe asynchronously; after release the block waits for iStart.

Verification (LAST_ADDR=3, DATA_INIT=8'h10, DATA_STEP=2)
REQ-035 Start, 4 ticks each acked after 2 cycles, iLoop=0 -> writes (0,10),(1,12),(2,14),(3,16); one oDone pulse; IDLE; oOverrun=0.
REQ-036 Same with iLoop=1, 6 ticks -> addresses 0,1,2,3,0,1, data 10,12,14,16,10,12; no oDone.
REQ-037 Tick while oWe high awaiting ack, and tick coincident with iAck -> each dropped, oOverrun=1, address sequence unchanged; cleared by next accepted iStart.
REQ-038 iStop during WRITE at addr 2 -> oWe=0 next cycle, IDLE, oAddr=2, no oDone; later iAck and iTick ignored.
REQ-039 Assert iRst_n=0 mid-WRITE between clock edges -> oWe, oBusy low without clock edge; all outputs at reset values.
REQ-040 iTick in IDLE and iStart while ARMED -> no write, no state change, oOverrun stays 0.
